// File: rtl/riscv_pc_pkg.sv
// Shared types and constants for the fetch PC unit: FSM states and the sequential PC step.
package riscv_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Redirect arbiter: picks trap over branch and rejects branch targets that break instruction alignment.
module pc_redirect_arb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned IALIGN = 32
) (
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_target_o,
  output logic            redir_misalign_o
);

  logic brMisaligned;

  // Alignment check on the branch target; trap vectors are trusted and never checked.
  always_comb begin
    brMisaligned = 1'b0;
    if (IALIGN == 16) begin
      brMisaligned = br_target_i[0];
    end else begin
      brMisaligned = |br_target_i[1:0];
    end
  end

  // Fixed priority: a trap wins, then an aligned branch; a misaligned branch only raises the flag.
  always_comb begin
    redir_valid_o    = 1'b0;
    redir_target_o   = br_target_i;
    redir_misalign_o = 1'b0;
    if (trap_i) begin
      redir_valid_o  = 1'b1;
      redir_target_o = trap_vec_i;
    end else if (br_taken_i) begin
      if (brMisaligned) begin
        redir_misalign_o = 1'b1;
      end else begin
        redir_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC and instruction-memory request unit: req/gnt handshake, redirect buffering, path tagging.
module pc_fetch_unit
  import riscv_pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     IALIGN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            out_q, out_d;
  logic            misalign_q;
  logic [XLEN-1:0] misalign_addr_q;

  logic            redirValid;
  logic [XLEN-1:0] redirTarget;
  logic            redirMisalign;
  logic            hs;

  pc_redirect_arb #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_arb (
    .br_taken_i       (br_taken_i),
    .br_target_i      (br_target_i),
    .trap_i           (trap_i),
    .trap_vec_i       (trap_vec_i),
    .redir_valid_o    (redirValid),
    .redir_target_o   (redirTarget),
    .redir_misalign_o (redirMisalign)
  );

  // An outstanding request is kept up regardless of stall; grant never feeds back into req.
  assign imem_req_o      = (state_q != BOOT) && (out_q || !stall_i);
  assign imem_addr_o     = pc_q;
  assign hs              = imem_req_o && imem_gnt_i;
  assign fetch_valid_o   = hs && (state_q == RUN) && !trap_i && !br_taken_i;
  assign fetch_pc_o      = pc_q;
  assign misalign_o      = misalign_q;
  assign misalign_addr_o = misalign_addr_q;

  // Next PC / state selection; a redirect that hits a waiting request is parked in pend until the grant.
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    pend_d  = pend_q;
    out_d   = imem_req_o && !imem_gnt_i;
    if (state_q == BOOT) begin
      if (redirValid) begin
        pc_d = redirTarget;
      end
      state_d = RUN;
    end else if (redirValid && imem_req_o && !imem_gnt_i) begin
      pend_d  = redirTarget;
      state_d = PEND;
    end else if (redirValid) begin
      pc_d    = redirTarget;
      state_d = RUN;
    end else if ((state_q == PEND) && hs) begin
      pc_d    = pend_q;
      state_d = RUN;
    end else if ((state_q == RUN) && hs) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  // Fetch state registers; reset discards any buffered redirect and restarts from BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  // Misalign report: one-cycle pulse, address held until the next rejected target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      misalign_q <= redirMisalign;
      if (redirMisalign) begin
        misalign_addr_q <= br_target_i;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a per-cycle vector table plus hand-written wrap and reset sequences.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        br_taken_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_vec_i = '0;
  logic        imem_gnt_i = 1'b1;

  logic        imem_req_o, fetch_valid_o, misalign_o;
  logic [31:0] imem_addr_o, fetch_pc_o, misalign_addr_o;

  logic        altReq, altValid, altMis;
  logic [31:0] altAddr, altPc, altMisAddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .br_taken_i      (br_taken_i),
    .br_target_i     (br_target_i),
    .trap_i          (trap_i),
    .trap_vec_i      (trap_vec_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .fetch_valid_o   (fetch_valid_o),
    .fetch_pc_o      (fetch_pc_o),
    .misalign_o      (misalign_o),
    .misalign_addr_o (misalign_addr_o)
  );

  // Same stimulus, 16-bit alignment: only used to show 0x102 is an accepted target here.
  pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(16)) dutAlt (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .br_taken_i      (br_taken_i),
    .br_target_i     (br_target_i),
    .trap_i          (trap_i),
    .trap_vec_i      (trap_vec_i),
    .imem_req_o      (altReq),
    .imem_addr_o     (altAddr),
    .imem_gnt_i      (imem_gnt_i),
    .fetch_valid_o   (altValid),
    .fetch_pc_o      (altPc),
    .misalign_o      (altMis),
    .misalign_addr_o (altMisAddr)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] brTarget;
    logic        trap;
    logic [31:0] trapVec;
    logic        gnt;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic        expMis;
    logic [31:0] expMisAddr;
    logic        chkAlt;
    logic [31:0] expAltAddr;
    logic        expAltMis;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  task automatic applyStimulus(input vec_t v);
    stall_i     = v.stall;
    br_taken_i  = v.br;
    br_target_i = v.brTarget;
    trap_i      = v.trap;
    trap_vec_i  = v.trapVec;
    imem_gnt_i  = v.gnt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle-by-cycle vectors: stall br target trap vec gnt | req addr valid mis misaddr | alt
    vecs[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h4,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h0,  1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b0, 1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h8,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h80,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[10] = '{1'b0, 1'b1, 32'h102, 1'b0, 32'h0,  1'b1, 1'b1, 32'h84,  1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h88,  1'b1, 1'b1, 32'h102, 1'b1, 32'h102, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b1, 32'h8C,  1'b1, 1'b0, 32'h102, 1'b0, 32'h0,   1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,  1'b1, 1'b0, 32'h90,  1'b0, 1'b0, 32'h102, 1'b0, 32'h0,   1'b0};

    // Held in reset: everything at its reset value.
    @(negedge clk);
    checkOutput("reset req", 32'(imem_req_o), 32'h0);
    checkOutput("reset valid", 32'(fetch_valid_o), 32'h0);
    checkOutput("reset addr", imem_addr_o, 32'h0);
    checkOutput("reset misalign", 32'(misalign_o), 32'h0);
    nextCycle();
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d req", i), 32'(imem_req_o), 32'(vecs[i].expReq));
      checkOutput($sformatf("v%0d addr", i), imem_addr_o, vecs[i].expAddr);
      checkOutput($sformatf("v%0d fetch_pc", i), fetch_pc_o, vecs[i].expAddr);
      checkOutput($sformatf("v%0d valid", i), 32'(fetch_valid_o), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d misalign", i), 32'(misalign_o), 32'(vecs[i].expMis));
      checkOutput($sformatf("v%0d misalign_addr", i), misalign_addr_o, vecs[i].expMisAddr);
      if (vecs[i].chkAlt) begin
        checkOutput($sformatf("v%0d ialign16 addr", i), altAddr, vecs[i].expAltAddr);
        checkOutput($sformatf("v%0d ialign16 misalign", i), 32'(altMis), 32'(vecs[i].expAltMis));
      end
      nextCycle();
    end

    // Wrap: trap to the top word, fetch it, then the PC rolls over to zero.
    stall_i = 1'b0; br_taken_i = 1'b0; trap_i = 1'b1; trap_vec_i = 32'hFFFF_FFFC; imem_gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("wrap trap-cycle valid", 32'(fetch_valid_o), 32'h0);
    checkOutput("wrap trap-cycle addr", imem_addr_o, 32'h90);
    nextCycle();
    trap_i = 1'b0;
    @(negedge clk);
    checkOutput("wrap top addr", imem_addr_o, 32'hFFFF_FFFC);
    checkOutput("wrap top valid", 32'(fetch_valid_o), 32'h1);
    nextCycle();
    imem_gnt_i = 1'b0;
    @(negedge clk);
    checkOutput("wrap zero addr", imem_addr_o, 32'h0);
    checkOutput("wrap zero req", 32'(imem_req_o), 32'h1);
    nextCycle();

    // Redirect during the wait state parks the unit in PEND.
    br_taken_i = 1'b1; br_target_i = 32'h40;
    @(negedge clk);
    checkOutput("pend addr held", imem_addr_o, 32'h0);
    checkOutput("pend req held", 32'(imem_req_o), 32'h1);
    nextCycle();
    br_taken_i = 1'b0;

    // Asynchronous reset mid-cycle while a request is still outstanding.
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async rst req", 32'(imem_req_o), 32'h0);
    checkOutput("async rst valid", 32'(fetch_valid_o), 32'h0);
    checkOutput("async rst misalign", 32'(misalign_o), 32'h0);
    checkOutput("async rst misalign_addr", misalign_addr_o, 32'h0);
    checkOutput("async rst addr", imem_addr_o, 32'h0);
    nextCycle();
    rst = 1'b0;
    imem_gnt_i = 1'b1;
    @(negedge clk);
    checkOutput("restart boot req", 32'(imem_req_o), 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("restart first addr", imem_addr_o, 32'h0);
    checkOutput("restart first valid", 32'(fetch_valid_o), 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("restart second addr", imem_addr_o, 32'h4);
    checkOutput("restart second valid", 32'(fetch_valid_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
